// File: rtl/arb_player_pkg.sv
// Shared types and helpers for arbiter_auto_player.
// Optional build macro: ARB_PLAYER_FIXED_DELAY_EN (fixed reaction delay, no LFSR).
package arb_player_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    REQ,
    HOLD,
    RELEASE
  } state_t;

  localparam logic [7:0]  LFSR_TAPS = 8'hB8;
  localparam int unsigned CNT_W     = 4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/arb_player_lfsr.sv
// 8-bit right-shifting Galois LFSR (x^8+x^6+x^5+x^4+1) with load-on-reset seed.
// Not used when ARB_PLAYER_FIXED_DELAY_EN is defined.
module arb_player_lfsr
  import arb_player_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] lfsr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else if (en) begin
      lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/arbiter_auto_player.sv
// Automatic requester for one arbiter req input: delayed request, hold, back-off, tallies.
// Build macro ARB_PLAYER_FIXED_DELAY_EN: use FIXED_DELAY instead of the LFSR delay.
module arbiter_auto_player
  import arb_player_pkg::*;
#(
  parameter logic [7:0]  LFSR_SEED   = 8'hA5,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [7:0]  FIXED_DELAY = 8'd20
) (
  input  logic             clk,
  input  logic             rst_in_n,
  input  logic             start_in,
  input  logic             grant_in,
  input  logic             other_grant_in,
  output logic             req_out,
  output logic             busy_out,
  output logic [CNT_W-1:0] win_cnt_out,
  output logic [CNT_W-1:0] loss_cnt_out
);

  localparam logic [7:0] HOLD_LAST    = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] delay;

`ifdef ARB_PLAYER_FIXED_DELAY_EN
  always_comb delay = FIXED_DELAY;
`else
  logic [7:0] lfsr;

  arb_player_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst_n(rst_in_n),
    .en   (1'b1),
    .lfsr (lfsr)
  );

  // Fallback only matters for an illegal zero seed; keeps D non-zero regardless.
  always_comb delay = (lfsr != '0) ? lfsr : FIXED_DELAY;
`endif

  // cnt is shared: counts down in WAIT, up from 0 in REQ (timeout) and HOLD.
  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state        <= IDLE;
      cnt          <= '0;
      req_out      <= 1'b0;
      busy_out     <= 1'b0;
      win_cnt_out  <= '0;
      loss_cnt_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            state    <= WAIT;
            cnt      <= delay;
            busy_out <= 1'b1;
          end
        end
        WAIT: begin
          if (other_grant_in) begin
            state        <= RELEASE;
            loss_cnt_out <= sat_inc(loss_cnt_out);
          end else if (cnt == 8'd1) begin
            state   <= REQ;
            cnt     <= '0;
            req_out <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        REQ: begin
          if (grant_in) begin
            state       <= HOLD;
            cnt         <= '0;
            win_cnt_out <= sat_inc(win_cnt_out);
          end else if (other_grant_in || cnt == TIMEOUT_LAST) begin
            state        <= RELEASE;
            req_out      <= 1'b0;
            loss_cnt_out <= sat_inc(loss_cnt_out);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state   <= RELEASE;
            req_out <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!grant_in && !other_grant_in) begin
            state    <= IDLE;
            busy_out <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          req_out  <= 1'b0;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_auto_player.sv
// Directed testbench for arbiter_auto_player (default LFSR build or ARB_PLAYER_FIXED_DELAY_EN).
module tb_arbiter_auto_player;

  localparam int K_WIN   = 0;
  localparam int K_BOTH  = 1;
  localparam int K_EARLY = 2;
  localparam int K_TMO   = 3;
  localparam int K_LATE  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_in = 1'b0;
  logic       grant_in = 1'b0;
  logic       other_grant_in = 1'b0;
  logic       req_out;
  logic       busy_out;
  logic [3:0] win_cnt_out;
  logic [3:0] loss_cnt_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_lfsr;

  arbiter_auto_player #(
    .LFSR_SEED  (8'hA5),
    .HOLD_CYCLES(16),
    .TIMEOUT    (255),
    .FIXED_DELAY(8'd20)
  ) dut (
    .clk           (clk),
    .rst_in_n      (rst_n),
    .start_in      (start_in),
    .grant_in      (grant_in),
    .other_grant_in(other_grant_in),
    .req_out       (req_out),
    .busy_out      (busy_out),
    .win_cnt_out   (win_cnt_out),
    .loss_cnt_out  (loss_cnt_out)
  );

  always #5 clk = ~clk;

  // Golden Galois LFSR, free running from reset like the design's delay source.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_lfsr <= 8'hA5;
    else        model_lfsr <= (model_lfsr >> 1) ^ (model_lfsr[0] ? 8'hB8 : 8'h00);
  end

  typedef struct {
    int kind;
    int offset;
    int exp_len;
    int exp_win;
    int exp_loss;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Called in the negedge phase; the next posedge samples start_in.
  task automatic run_round(input int kind, input int g, input bit poke,
                           input int exp_len, input int exp_win, input int exp_loss);
    int d;
    int n;
    int m;
    int eff;
    bit saw_req;
    start_in = 1'b1;
`ifdef ARB_PLAYER_FIXED_DELAY_EN
    d = 20;
`else
    d = int'(model_lfsr);
`endif
    @(posedge clk); #1;
    start_in = 1'b0;
    check("busy_after_start", int'(busy_out), 1);
    check("req_after_start", int'(req_out), 0);
    if (kind == K_EARLY) begin
      eff = (g < d) ? g : 1;
      repeat (eff - 1) @(posedge clk);
      @(negedge clk);
      other_grant_in = 1'b1;
      saw_req = 1'b0;
      for (int i = 0; i < d + 3; i++) begin
        @(posedge clk); #1;
        if (req_out) saw_req = 1'b1;
      end
      check("early_no_req", int'(saw_req), 0);
      check("early_release_held", int'(busy_out), 1);
    end else begin
      n = 0;
      while (!req_out && n < 300) begin
        @(posedge clk); #1;
        n++;
      end
      check("req_latency", n, d);
      m = 0;
      while (req_out && m < 400) begin
        @(negedge clk);
        if (m == g - 1) begin
          if (kind == K_WIN || kind == K_BOTH) grant_in = 1'b1;
          if (kind == K_BOTH || kind == K_LATE) other_grant_in = 1'b1;
        end
        start_in = poke && (m == g + 2);
        @(posedge clk); #1;
        m++;
      end
      start_in = 1'b0;
      check("req_high_len", m, exp_len);
      check("release_busy", int'(busy_out), 1);
      if (kind != K_TMO) begin
        @(posedge clk); #1;
        check("release_held", int'(busy_out), 1);
      end
    end
    @(negedge clk);
    grant_in = 1'b0;
    other_grant_in = 1'b0;
    @(posedge clk); #1;
    check("back_to_idle", int'(busy_out), 0);
    check("req_idle", int'(req_out), 0);
    check("win_cnt", int'(win_cnt_out), exp_win);
    check("loss_cnt", int'(loss_cnt_out), exp_loss);
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      check("no_extra_round", int'(busy_out), 0);
    end
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{kind: K_WIN,   offset: 5, exp_len: 21,  exp_win: 1, exp_loss: 0};
    vecs[1] = '{kind: K_EARLY, offset: 10, exp_len: 0,  exp_win: 1, exp_loss: 1};
    vecs[2] = '{kind: K_TMO,   offset: 0, exp_len: 255, exp_win: 1, exp_loss: 2};
    vecs[3] = '{kind: K_BOTH,  offset: 3, exp_len: 19,  exp_win: 2, exp_loss: 2};
    vecs[4] = '{kind: K_LATE,  offset: 7, exp_len: 7,   exp_win: 2, exp_loss: 3};

    #12;
    check("rst_req", int'(req_out), 0);
    check("rst_busy", int'(busy_out), 0);
    check("rst_win", int'(win_cnt_out), 0);
    check("rst_loss", int'(loss_cnt_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      run_round(vecs[i].kind, vecs[i].offset, 1'b0,
                vecs[i].exp_len, vecs[i].exp_win, vecs[i].exp_loss);

    // Win streak: tally saturates at 15; one round pokes start_in during HOLD.
    for (int i = 0; i < 15; i++)
      run_round(K_WIN, 1, (i == 3), 17, ((3 + i) > 15) ? 15 : (3 + i), 3);
    check("win_saturated", int'(win_cnt_out), 15);

    // Asynchronous reset in the middle of WAIT.
    start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    check("mid_wait_busy", int'(busy_out), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", int'(req_out), 0);
    check("async_rst_busy", int'(busy_out), 0);
    check("async_rst_win", int'(win_cnt_out), 0);
    check("async_rst_loss", int'(loss_cnt_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_round(K_WIN, 2, 1'b0, 18, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
